// File: rtl/hybrid_encrypt_core.sv
// Sequential Vigenere + Polybius cipher: one character per clock, start/done handshake.
// Optional HYBRID_ENC_LOWERCASE_EN folds 'a'..'z' in message and key to uppercase.
module hybrid_encrypt_core #(
  parameter int unsigned N = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8*N-1:0]    message,
  input  logic [8*N-1:0]    key,
  output logic              busy,
  output logic              done,
  output logic [16*N-1:0]   encrypted_hybrid
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [8*N-1:0]    msg_q, msg_d;
  logic [8*N-1:0]    key_q, key_d;
  logic [16*N-1:0]   out_q, out_d;
  logic              done_q, done_d;

  logic [7:0]  m_chr, k_chr;
  logic        m_letter, k_letter;
  logic [5:0]  m_off, k_off, sum6;
  logic [4:0]  pidx, row, col;
  logic [15:0] slot;

  // Message and key shift left each step, so the current character is always the top byte.
  always_comb begin
    m_chr = msg_q[8*N-1 -: 8];
    k_chr = key_q[8*N-1 -: 8];
`ifdef HYBRID_ENC_LOWERCASE_EN
    if (m_chr >= 8'h61 && m_chr <= 8'h7A) m_chr = m_chr - 8'h20;
    if (k_chr >= 8'h61 && k_chr <= 8'h7A) k_chr = k_chr - 8'h20;
`endif
    m_letter = (m_chr >= 8'h41) && (m_chr <= 8'h5A);
    k_letter = (k_chr >= 8'h41) && (k_chr <= 8'h5A);
    // Low six bits of 'A'..'Z' are 1..26, so subtracting 1 yields the 0..25 offset.
    m_off = m_chr[5:0] - 6'd1;
    k_off = k_letter ? (k_chr[5:0] - 6'd1) : 6'd0;
    sum6  = m_off + k_off;
    if (sum6 >= 6'd26) sum6 = sum6 - 6'd26;
    if (sum6[4:0] < 5'd9)       pidx = sum6[4:0];
    else if (sum6[4:0] == 5'd9) pidx = 5'd8;
    else                        pidx = sum6[4:0] - 5'd1;
    row  = pidx / 5'd5;
    col  = pidx % 5'd5;
    slot = m_letter ? {8'h31 + {3'b000, row}, 8'h31 + {3'b000, col}} : 16'h3030;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    msg_d   = msg_q;
    key_d   = key_q;
    out_d   = out_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          msg_d   = message;
          key_d   = key;
          idx_d   = '0;
        end
      end
      StRun: begin
        out_d[16*(N-1-int'(idx_q)) +: 16] = slot;
        msg_d = msg_q << 8;
        key_d = key_q << 8;
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxW'(N-1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      msg_q   <= '0;
      key_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      msg_q   <= msg_d;
      key_q   <= key_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign busy             = (state_q == StRun);
  assign done             = done_q;
  assign encrypted_hybrid = out_q;

endmodule

// File: tb/tb_hybrid_encrypt_core.sv
// Scoreboard bench for hybrid_encrypt_core: driver pushes expected results, monitor checks on done.
module tb_hybrid_encrypt_core;
  localparam int unsigned N = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [8*N-1:0]  message = '0;
  logic [8*N-1:0]  key = '0;
  logic            busy, done;
  logic [16*N-1:0] encrypted_hybrid;

  int tests = 0;
  int fails = 0;
  logic [16*N-1:0] exp_q[$];
  logic [16*N-1:0] last_exp = '0;
  int run_cnt = 0;
  logic done_prev = 1'b0;

  hybrid_encrypt_core #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .message(message), .key(key),
    .busy(busy), .done(done), .encrypted_hybrid(encrypted_hybrid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [16*N-1:0] act, input logic [16*N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain alphabet arithmetic and a lookup in the 25-letter square.
  function automatic logic [16*N-1:0] model(input logic [8*N-1:0] msg, input logic [8*N-1:0] k);
    string sq = "ABCDEFGHIKLMNOPQRSTUVWXYZ";
    logic [16*N-1:0] r = '0;
    for (int i = 0; i < int'(N); i++) begin
      int m = int'(msg[8*(N-1-i) +: 8]);
      int kc = int'(k[8*(N-1-i) +: 8]);
      int s, ch, p;
`ifdef HYBRID_ENC_LOWERCASE_EN
      if (m >= 97 && m <= 122) m -= 32;
      if (kc >= 97 && kc <= 122) kc -= 32;
`endif
      if (m < 65 || m > 90) begin
        r[16*(N-1-i) +: 16] = 16'h3030;
      end else begin
        s  = (kc >= 65 && kc <= 90) ? kc - 65 : 0;
        ch = 65 + (m - 65 + s) % 26;
        if (ch == 74) ch = 73;
        p = 0;
        for (int j = 0; j < 25; j++) if (int'(sq[j]) == ch) p = j;
        r[16*(N-1-i) +: 16] = {8'(48 + p / 5 + 1), 8'(48 + p % 5 + 1)};
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] rnd_chr();
    case ($urandom_range(0, 3))
      0, 1: return 8'(65 + $urandom_range(0, 25));
      2:    return 8'(97 + $urandom_range(0, 25));
      default: return 8'(32 + $urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [8*N-1:0] rnd_str();
    logic [8*N-1:0] v;
    for (int i = 0; i < int'(N); i++) v[8*i +: 8] = rnd_chr();
    return v;
  endfunction

  // Monitor: counts busy cycles and checks result, latency and pulse width on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_cnt = 0;
    end else begin
      if (done) begin
        chk("latency", 192'(run_cnt), 192'(N));
        if (exp_q.size() == 0) chk("unexpected_done", 192'(1), 192'(0));
        else chk("result", encrypted_hybrid, exp_q.pop_front());
        if (done_prev) chk("done_pulse_width", 192'(done_prev), 192'(0));
        run_cnt = 0;
      end
      if (busy) run_cnt++;
    end
    done_prev = done;
  end

  // ghost_start: pulses start at cycles 3 and 5; abort_at: reset mid-job at that cycle (0 = never).
  task automatic run_job(input logic [8*N-1:0] m, input logic [8*N-1:0] k,
                         input logic [16*N-1:0] exp, input bit ghost_start, input int abort_at);
    @(negedge clk);
    message = m;
    key     = k;
    start   = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    chk("busy_at_latch", 192'(busy), 192'(1));
    start = 1'b0;
    for (int c = 1; c <= int'(N); c++) begin
      message = rnd_str();
      key     = rnd_str();
      start   = ghost_start && (c == 3 || c == 5);
      @(posedge clk);
      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", 192'(busy), 192'(0));
        chk("reset_done", 192'(done), 192'(0));
        chk("reset_out", encrypted_hybrid, '0);
        void'(exp_q.pop_back());
        last_exp = '0;
        start = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        return;
      end
      #1;
      if (c < int'(N) && (c % 4 == 1)) chk("busy_in_job", 192'(busy), 192'(1));
    end
    start = 1'b0;
    chk("busy_after_job", 192'(busy), 192'(0));
    last_exp = exp;
  endtask

  initial begin
    logic [8*N-1:0] m1 = "VAMSIKRISHNA";
    logic [8*N-1:0] k1 = "NAGARAVINDRA";
    logic [16*N-1:0] e1 = "241143435525324121251511";
    logic [16*N-1:0] e6;
    logic [8*N-1:0] rm, rk;
`ifdef HYBRID_ENC_LOWERCASE_EN
    e6 = "241143435525324121251511";
`else
    e6 = "000000000000000000000000";
`endif
    #12;
    chk("rst_busy", 192'(busy), 192'(0));
    chk("rst_done", 192'(done), 192'(0));
    chk("rst_out", encrypted_hybrid, '0);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_job(m1, k1, e1, 1'b0, 0);
    run_job("JIZZABCDEFGH", "AAAAAAAAAAAA", "242455551112131415212223", 1'b0, 0);
    run_job("ZY7AAAAAAAAA", "BZA?AAAAAAAA", "115300111111111111111111", 1'b0, 0);
    run_job(m1, k1, e1, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i % 3 == 0) chk("hold_out", encrypted_hybrid, last_exp);
      if (i % 3 == 1) chk("hold_done", 192'(done), 192'(0));
    end
    run_job("ZZZZZZZZZZZZ", "ZZZZZZZZZZZZ", '0, 1'b0, 6);
    run_job(m1, k1, e1, 1'b0, 0);
    run_job("vamsikrishna", "nagaravindra", e6, 1'b0, 0);
    for (int t = 0; t < 12; t++) begin
      rm = rnd_str();
      rk = rnd_str();
      run_job(rm, rk, model(rm, rk), 1'b0, 0);
    end
    repeat (3) @(posedge clk);
    chk("pending_expected", 192'(exp_q.size()), 192'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/hybrid_encrypt_core.md
Name: hybrid_encrypt_core

Overview:
Two-stage classical cipher engine.
- Stage 1: Vigenère-encrypts an N-character ASCII message with an N-character ASCII key.
- Stage 2: maps each Vigenère letter to its Polybius-square coordinates, output as two ASCII digits.
- Sequential: processes one character per clock under a start/done handshake.
- Sits behind the cipher-demo host interface; the result is a 16*N-bit ASCII digit string.

Parameters:
N, 12, number of message/key characters (N >= 1).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
message  input  8*N  ASCII message; char 0 in bits [8N-1:8N-8]
key  input  8*N  ASCII key; same packing as message
busy  output  1  high while a job is latched or running
done  output  1  one-cycle pulse, result complete
encrypted_hybrid  output  16*N  result; char i in bits [16(N-1-i)+15 -: 16], high byte = row digit, low byte = column digit

Behaviour:
- Reset (rst_n=0, asynchronous, any state including mid-job):
  - FSM to IDLE; busy=0, done=0, encrypted_hybrid all zero, index=0.
  - A job interrupted by reset is discarded.
- FSM states:
  - IDLE --start--> RUN. On that edge (edge 0): latch message and key into internal registers, index=0, busy=1.
  - RUN: at each edge k (k=1..N), process char index k-1 and write its 16-bit slot. After edge N, go to IDLE with done=1 and busy=0.
  - IDLE: done returns to 0 on the next edge.
- Latency: done is high for exactly one cycle, after the N-th edge following the start-sampling edge.
- Input and output stability:
  - start while busy is ignored.
  - Input changes after the latch edge do not affect the job.
  - encrypted_hybrid holds its value until the next accepted start.
  - Slots not yet written during a job keep their previous contents.
- Letter test: message char m is a letter iff 'A'(0x41) <= m <= 'Z'(0x5A).
- Vigenère:
  - Shift s = k-'A' if the key char k is in 'A'..'Z', else s=0.
  - c = ((m-'A') + s) mod 26, computed in 6-bit arithmetic with a single conditional subtract of 26.
- Polybius square, 5x5, J merged into I. Rows:
  - row 1: A B C D E
  - row 2: F G H I K
  - row 3: L M N O P
  - row 4: Q R S T U
  - row 5: V W X Y Z
- Polybius index calculation:
  - idx = c if c<9; idx = 8 if c==9 (J); idx = c-1 if c>9.
  - row = idx/5+1, col = idx%5+1.
  - Output bytes: 0x30+row, 0x30+col.
- Non-letter message char: slot = "00" (0x3030).

Optional Feature:
HYBRID_ENC_LOWERCASE_EN
- Defined: message and key chars 'a'..'z' are folded to uppercase before use, and encrypt identically to their uppercase form.
- Undefined: lowercase message chars are non-letters (output "00"), and lowercase key chars give shift 0.

Test Plan:
1. N=12, message "VAMSIKRISHNA", key "NAGARAVINDRA", pulse start.
   - done exactly 12 cycles after the start edge.
   - Output ASCII "241143435525324121251511" (Vigenère intermediate IASSZKMQFKEA).
2. N=12, key "AAAAAAAAAAAA", message "JIZZABCDEFGH".
   - Output "242455551112131415212223" (J and I both give 24).
3. Wrap-around: message "Z" + key "B" gives 'A' -> "11"; message "Y" + key "Z" gives 'X' -> "53". Non-letter '7' -> "00"; key char '?' gives shift 0.
4. Handshake:
   - Assert start again at cycles 3 and 5 of a job: ignored.
   - busy stays high through the job; done is a single-cycle pulse.
   - Output is unchanged for 10 idle cycles afterward.
5. Reset mid-operation:
   - Drop rst_n at cycle 6 of a job: busy=0, done=0 and output zero immediately, without waiting for a clock.
   - A fresh start after release reproduces the scenario-1 result.
6. With HYBRID_ENC_LOWERCASE_EN: message "vamsikrishna", key "nagaravindra" -> "241143435525324121251511". Without the macro: all twelve slots are "00".
